// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C bus conditioner.
// Filter length applies only when I2C_DIGFILT_EN is defined.
package i2c_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN        = 3;
    localparam int CNT_W           = 4;
    localparam int ACK_IDX         = 8;
endpackage

// File: rtl/i2c_sync_filt.sv
// i2c_sync_filt: multi-flop synchronizer with optional majority-free run-length filter.
// Build with I2C_DIGFILT_EN defined to enable the FILT_LEN-sample stability filter.
module i2c_sync_filt
    import i2c_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic              s;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign s = sync_q[STAGES-1];

`ifdef I2C_DIGFILT_EN
    logic [FILT_LEN-2:0] hist_q;
    logic                filt_q;

    // Output follows the line only once FILT_LEN consecutive samples agree.
    assign q_o = (&{s, hist_q}) ? 1'b1 : (~|{s, hist_q}) ? 1'b0 : filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[FILT_LEN-3:0], s};
            filt_q <= q_o;
        end
    end
`else
    assign q_o = s;
`endif
endmodule

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: I2C START/STOP detection, busy tracking and byte/ACK capture.
// Define I2C_DIGFILT_EN to insert a 3-sample digital filter after each synchronizer.
module i2c_bus_cond
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       START_DET,
    output logic       STOP_DET,
    output logic       BUS_BUSY,
    output logic       BYTE_VLD,
    output logic [7:0] BYTE_DATA,
    output logic       ACK_VLD,
    output logic       ACK_VAL
);
    logic             scl_q, sda_q, scl_p_q, sda_p_q;
    logic             start, stop, rise;
    logic             start_q, stop_q, busy_q, byte_vld_q, ack_vld_q, ack_val_q;
    logic             busy_d, byte_vld_d, ack_vld_d, ack_val_d;
    logic [7:0]       byte_q, byte_d, shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    i2c_sync_filt #(.STAGES(SYNC_STAGES)) u_scl (.clk(CLK), .rst(RST), .d_i(SCL_IN), .q_o(scl_q));
    i2c_sync_filt #(.STAGES(SYNC_STAGES)) u_sda (.clk(CLK), .rst(RST), .d_i(SDA_IN), .q_o(sda_q));

    assign start = sda_p_q & ~sda_q & scl_p_q & scl_q;
    assign stop  = ~sda_p_q & sda_q & scl_p_q & scl_q;
    // A rise coinciding with an SDA change is ambiguous, so it is not sampled.
    assign rise  = ~scl_p_q & scl_q & (sda_p_q == sda_q) & busy_q;

    always_comb begin
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        byte_d     = byte_q;
        ack_val_d  = ack_val_q;
        byte_vld_d = 1'b0;
        ack_vld_d  = 1'b0;
        busy_d     = start_q ? 1'b1 : stop_q ? 1'b0 : busy_q;
        if (start || stop) begin
            cnt_d    = '0;
            shadow_d = '0;
        end else if (rise) begin
            if (cnt_q == CNT_W'(ACK_IDX)) begin
                ack_val_d = sda_q;
                ack_vld_d = 1'b1;
                cnt_d     = '0;
            end else begin
                shadow_d   = {shadow_q[6:0], sda_q};
                byte_d     = (cnt_q == CNT_W'(ACK_IDX - 1)) ? shadow_d : byte_q;
                byte_vld_d = (cnt_q == CNT_W'(ACK_IDX - 1));
                cnt_d      = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            byte_vld_q <= 1'b0;
            ack_vld_q  <= 1'b0;
            ack_val_q  <= 1'b1;
            byte_q     <= 8'h00;
            shadow_q   <= 8'h00;
            cnt_q      <= '0;
        end else begin
            scl_p_q    <= scl_q;
            sda_p_q    <= sda_q;
            start_q    <= start;
            stop_q     <= stop;
            busy_q     <= busy_d;
            byte_vld_q <= byte_vld_d;
            ack_vld_q  <= ack_vld_d;
            ack_val_q  <= ack_val_d;
            byte_q     <= byte_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign START_DET = start_q;
    assign STOP_DET  = stop_q;
    assign BUS_BUSY  = busy_q;
    assign BYTE_VLD  = byte_vld_q;
    assign BYTE_DATA = byte_q;
    assign ACK_VLD   = ack_vld_q;
    assign ACK_VAL   = ack_val_q;
endmodule

// File: tb/tb_i2c_bus_cond.sv
// tb_i2c_bus_cond: scoreboard bench for i2c_bus_cond with directed bus transactions.
// Filter-specific glitch cases run when I2C_DIGFILT_EN is defined.
module tb_i2c_bus_cond;
    localparam int SS = 3;
    localparam int Q  = 4;
`ifdef I2C_DIGFILT_EN
    localparam int LAT = SS + 3;
`else
    localparam int LAT = SS + 1;
`endif

    typedef enum logic [1:0] {EV_START, EV_STOP, EV_BYTE, EV_ACK} ev_t;
    typedef struct packed {
        ev_t        kind;
        logic [7:0] data;
    } ev_s;

    logic       CLK = 0, RST = 1, SCL_IN = 1, SDA_IN = 1;
    logic       START_DET, STOP_DET, BUS_BUSY, BYTE_VLD, ACK_VLD, ACK_VAL;
    logic [7:0] BYTE_DATA;
    ev_s        exp_q[$];
    int         checks = 0, errors = 0;

    i2c_bus_cond #(.SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RST(RST), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN),
        .START_DET(START_DET), .STOP_DET(STOP_DET), .BUS_BUSY(BUS_BUSY),
        .BYTE_VLD(BYTE_VLD), .BYTE_DATA(BYTE_DATA), .ACK_VLD(ACK_VLD), .ACK_VAL(ACK_VAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input ev_t k, input logic [7:0] d);
        ev_s e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_t k, input logic [7:0] d, input string nm);
        ev_s e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected %s got data %0h want no event", nm, d);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " kind"}, 32'(k), 32'(e.kind));
            if (k == EV_BYTE || k == EV_ACK) chk({nm, " data"}, 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (START_DET) got(EV_START, 8'h00, "start");
            if (STOP_DET)  got(EV_STOP, 8'h00, "stop");
            if (BYTE_VLD)  got(EV_BYTE, BYTE_DATA, "byte");
            if (ACK_VLD)   got(EV_ACK, {7'b0, ACK_VAL}, "ack");
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_cond();
        SDA_IN = 0;
        push(EV_START, 8'h00);
        cyc(Q);
        SCL_IN = 0;
        cyc(Q);
    endtask

    task automatic stop_cond();
        SDA_IN = 0;
        cyc(Q);
        SCL_IN = 1;
        cyc(Q);
        SDA_IN = 1;
        push(EV_STOP, 8'h00);
        cyc(Q);
    endtask

    task automatic send_bit(input logic b);
        SDA_IN = b;
        cyc(Q);
        SCL_IN = 1;
        cyc(Q);
        SCL_IN = 0;
        cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) push(EV_BYTE, d);
            send_bit(d[i]);
        end
        push(EV_ACK, {7'b0, ack});
        send_bit(ack);
    endtask

    initial begin
        int n;
        cyc(3);
        chk("rst start_det", 32'(START_DET), 0);
        chk("rst stop_det", 32'(STOP_DET), 0);
        chk("rst busy", 32'(BUS_BUSY), 0);
        chk("rst byte_vld", 32'(BYTE_VLD), 0);
        chk("rst byte_data", 32'(BYTE_DATA), 0);
        chk("rst ack_vld", 32'(ACK_VLD), 0);
        chk("rst ack_val", 32'(ACK_VAL), 1);
        RST = 0;
        cyc(10);

        // Transaction 1: START latency, A5 with ACK, STOP
        SDA_IN = 0;
        push(EV_START, 8'h00);
        n = 0;
        while (!START_DET && n < 20) begin
            cyc(1);
            n++;
        end
        chk("start latency", 32'(n), 32'(LAT));
        cyc(Q);
        chk("busy after start", 32'(BUS_BUSY), 1);
        SCL_IN = 0;
        cyc(Q);
        send_byte(8'hA5, 1'b0);
        chk("busy mid", 32'(BUS_BUSY), 1);
        stop_cond();
        cyc(2 * Q);
        chk("busy after stop", 32'(BUS_BUSY), 0);
        chk("byte held", 32'(BYTE_DATA), 32'h A5);
        chk("ack held", 32'(ACK_VAL), 0);

        // Transaction 2: partial byte, repeated START, 3C with NACK
        start_cond();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        SDA_IN = 1;
        cyc(Q);
        SCL_IN = 1;
        cyc(Q);
        SDA_IN = 0;
        push(EV_START, 8'h00);
        cyc(2 * Q);
        chk("busy rep start", 32'(BUS_BUSY), 1);
        SCL_IN = 0;
        cyc(Q);
        send_byte(8'h3C, 1'b1);
        chk("busy after rep", 32'(BUS_BUSY), 1);
        chk("nack val", 32'(ACK_VAL), 1);
        stop_cond();
        cyc(2 * Q);

        // Idle SCL toggling and simultaneous SCL/SDA changes
        for (int i = 0; i < 3; i++) begin
            SCL_IN = 0;
            cyc(Q);
            SCL_IN = 1;
            cyc(Q);
        end
        SCL_IN = 0;
        cyc(Q);
        SCL_IN = 1; SDA_IN = 0;
        cyc(Q);
        SCL_IN = 0; SDA_IN = 1;
        cyc(Q);
        SCL_IN = 1;
        cyc(2 * Q);
        chk("idle busy", 32'(BUS_BUSY), 0);

        // Reset after 5 bits, then FF
        start_cond();
        for (int i = 0; i < 5; i++) send_bit(1'(i));
        SDA_IN = 1;
        cyc(Q);
        RST = 1;
        cyc(2);
        RST = 0;
        chk("midrst busy", 32'(BUS_BUSY), 0);
        chk("midrst byte", 32'(BYTE_DATA), 0);
        chk("midrst ack", 32'(ACK_VAL), 1);
        cyc(2 * Q);
        SCL_IN = 1;
        cyc(2 * Q);
        start_cond();
        send_byte(8'hFF, 1'b0);
        stop_cond();
        cyc(2 * Q);
        chk("ff data", 32'(BYTE_DATA), 32'hFF);

`ifdef I2C_DIGFILT_EN
        SDA_IN = 0;
        cyc(2);
        SDA_IN = 1;
        cyc(4 * Q);
        chk("glitch busy", 32'(BUS_BUSY), 0);
        SDA_IN = 0;
        push(EV_START, 8'h00);
        n = 0;
        fork
            begin
                cyc(3);
                SDA_IN = 1;
                push(EV_STOP, 8'h00);
            end
            while (!START_DET && n < 20) begin
                cyc(1);
                n++;
            end
        join
        chk("filt start latency", 32'(n), 32'(LAT));
        cyc(4 * Q);
        chk("filt busy end", 32'(BUS_BUSY), 0);
`endif

        cyc(20);
        chk("queue drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_bus_cond.md
I2C_BUS_COND -- requirements
Module: i2c_bus_cond

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per input (legal 2..4).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port SCL_IN  input  1  deglitched SCL from the analog filter stage, asynchronous to CLK.
REQ-005 SHALL have port SDA_IN  input  1  deglitched SDA from the analog filter stage, asynchronous to CLK.
REQ-006 SHALL have port START_DET  output  1  one-cycle pulse: START or repeated START.
REQ-007 SHALL have port STOP_DET  output  1  one-cycle pulse: STOP.
REQ-008 SHALL have port BUS_BUSY  output  1  high from START until STOP.
REQ-009 SHALL have port BYTE_VLD  output  1  one-cycle pulse: 8 data bits received.
REQ-010 SHALL have port BYTE_DATA  output  8  last received byte, MSB first on bus; held until next BYTE_VLD.
REQ-011 SHALL have port ACK_VLD  output  1  one-cycle pulse: 9th bit sampled.
REQ-012 SHALL have port ACK_VAL  output  1  sampled 9th bit (0 = ACK); held until next ACK_VLD.

Function
REQ-013 SHALL synchronize SCL_IN and SDA_IN through SYNC_STAGES flops, then one history flop each (scl_q/sda_q, scl_p/sda_p).
REQ-014 SHALL detect START when sda_p=1, sda_q=0, scl_p=1, scl_q=1.
REQ-015 SHALL detect STOP when sda_p=0, sda_q=1, scl_p=1, scl_q=1.
REQ-016 SHALL detect no START/STOP and sample no bit in a cycle where SCL and SDA both change.
REQ-017 SHALL assert each pulse output exactly SYNC_STAGES+1 CLK edges after the causing input edge (digital filter disabled).
REQ-018 SHALL sample sda_q on SCL rise (scl_p=0, scl_q=1) only while BUS_BUSY=1; rises while idle ignored.
REQ-019 SHALL keep a 4-bit bit counter 0..8: counts 0..7 shift into BYTE_DATA shadow MSB-first; on count 7 load BYTE_DATA and pulse BYTE_VLD; count 8 loads ACK_VAL and pulses ACK_VLD; counter wraps 8 -> 0.
REQ-020 SHALL clear the bit counter and shadow register on START (incl. repeated START mid-byte, no BYTE_VLD for partial byte).
REQ-021 SHALL clear the bit counter on STOP, deassert BUS_BUSY the cycle after STOP_DET, discard partial bytes.
REQ-022 SHALL set BUS_BUSY the cycle after START_DET; repeated START keeps it high.
REQ-023 SHALL never assert START_DET and STOP_DET in the same cycle.

Reset
REQ-024 SHALL, on RST=1 at a CLK edge, set all synchronizer/history flops to 1 (idle bus), bit counter 0, BUS_BUSY 0, all pulses 0, BYTE_DATA 8'h00, ACK_VAL 1.
REQ-025 SHALL, on reset mid-byte, discard the transfer and require a new START before sampling.

Configuration
REQ-026 SHALL support macro I2C_DIGFILT_EN: when defined, each synchronized line passes a filter updating its output only after 3 consecutive equal samples (+2 cycles latency, pulses < 3 CLK ignored); when undefined, synchronized value used directly.

Structure
REQ-027 SHALL place SYNC_STAGES default, filter length (3), bit count width (4) and ACK bit index (8) in shared package i2c_pkg.
REQ-028 SHALL implement synchronizer plus optional filter as sub-module i2c_sync_filt, instantiated once for SCL and once for SDA.

Verification
REQ-029 Reset with lines high -> all outputs at REQ-024 values, BUS_BUSY=0.
REQ-030 START, byte 8'hA5, ACK=0, STOP -> START_DET once, BYTE_VLD with BYTE_DATA=8'hA5, ACK_VLD with ACK_VAL=0, STOP_DET once, BUS_BUSY 1 then 0.
REQ-031 START, 4 bits, repeated START, byte 8'h3C, NACK -> no BYTE_VLD for partial, then 8'h3C, ACK_VAL=1, BUS_BUSY stays 1.
REQ-032 SCL toggling with no START -> no BYTE_VLD/ACK_VLD; SCL and SDA changed same input cycle -> no START/STOP.
REQ-033 RST asserted after 5 bits, then new START and byte 8'hFF -> only 8'hFF reported.
REQ-034 I2C_DIGFILT_EN defined, 2-cycle SDA low pulse while SCL high -> no START_DET; 3-cycle pulse -> START_DET at SYNC_STAGES+3 edges.
